// File: rtl/mem_stage_vlat_if.sv
// Bundle of the EX->MEM handshake, data-memory response, MEM->WB
// handshake and the forwarding path back to ID for mem_stage_vlat.
interface mem_stage_vlat_if #(
  parameter int PC_W = 32
);
  // EX -> MEM
  logic            in_valid;
  logic            in_ready;
  logic [PC_W-1:0] in_pc;
  logic [31:0]     in_addr;
  logic [1:0]      in_ld_size;
  logic            in_ld_signed;
  logic            in_wait_resp;
  logic [4:0]      in_dest;
  logic            in_gr_we;
  logic            in_ex;
  logic            in_ertn;

  // data-memory response
  logic            data_ok;
  logic [31:0]     rdata;

  // MEM -> WB
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      out_dest;
  logic [31:0]     out_result;
  logic            out_gr_we;
  logic            out_ex;
  logic            out_ertn;

  // MEM -> ID forwarding
  logic [4:0]      fwd_dest;
  logic [31:0]     fwd_data;
  logic            fwd_stall;

  // Pipeline driver side (EX, memory, WB, ID collectively)
  modport master (
    output in_valid, in_pc, in_addr, in_ld_size, in_ld_signed, in_wait_resp,
           in_dest, in_gr_we, in_ex, in_ertn, data_ok, rdata, out_ready,
    input  in_ready, out_valid, out_pc, out_dest, out_result, out_gr_we,
           out_ex, out_ertn, fwd_dest, fwd_data, fwd_stall
  );

  // The MEM stage itself
  modport slave (
    input  in_valid, in_pc, in_addr, in_ld_size, in_ld_signed, in_wait_resp,
           in_dest, in_gr_we, in_ex, in_ertn, data_ok, rdata, out_ready,
    output in_ready, out_valid, out_pc, out_dest, out_result, out_gr_we,
           out_ex, out_ertn, fwd_dest, fwd_data, fwd_stall
  );
endinterface

// File: rtl/mem_stage_vlat.sv
// MEM pipeline stage with a variable-latency data-memory response.
// Holds one instruction, parks early load data in a one-entry buffer while
// WB stalls, and counts responses owed to flushed instructions so they can
// be dropped when they finally arrive.
module mem_stage_vlat #(
  parameter int PC_W       = 32,
  parameter int CANCEL_MAX = 3,
  parameter int CNT_W      = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  output logic            cancel_ovf_o,
  mem_stage_vlat_if.slave bus
);

  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     addr_q, addr_d;
  logic [1:0]      ldSize_q, ldSize_d;
  logic            ldSigned_q, ldSigned_d;
  logic            waitResp_q, waitResp_d;
  logic [4:0]      dest_q, dest_d;
  logic            grWe_q, grWe_d;
  logic            ex_q, ex_d;
  logic            ertn_q, ertn_d;
  logic            bufFlag_q, bufFlag_d;
  logic [31:0]     buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic        cntZero;
  logic        cntFull;
  logic        respHere;
  logic        readyGo;
  logic        inReady;
  logic        consume;
  logic        dropResp;
  logic        needCancel;
  logic [31:0] rd;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic [31:0] result;

  // Handshake terms: the held instruction may leave once any response it owes has arrived
  always_comb begin
    cntZero    = (cnt_q == '0);
    cntFull    = (cnt_q == CNT_W'(CANCEL_MAX));
    respHere   = (bus.data_ok & cntZero) | bufFlag_q;
    readyGo    = ~waitResp_q | respHere;
    inReady    = ~valid_q | (readyGo & bus.out_ready);
    consume    = bus.data_ok & cntZero & valid_q & waitResp_q & ~bufFlag_q;
    dropResp   = bus.data_ok & ~cntZero;
    needCancel = flush_i & valid_q & waitResp_q & ~respHere;
  end

  // Load extraction from either the parked buffer or the live response
  always_comb begin
    rd = bufFlag_q ? buf_q : bus.rdata;
    case (addr_q[1:0])
      2'b00:   ldByte = rd[7:0];
      2'b01:   ldByte = rd[15:8];
      2'b10:   ldByte = rd[23:16];
      default: ldByte = rd[31:24];
    endcase
    ldHalf = addr_q[1] ? rd[31:16] : rd[15:0];
    case (ldSize_q)
      2'b01:   result = {{24{ldSigned_q & ldByte[7]}}, ldByte};
      2'b10:   result = {{16{ldSigned_q & ldHalf[15]}}, ldHalf};
      2'b11:   result = rd;
      default: result = addr_q;
    endcase
  end

  // Next-state for the payload, the response buffer and the cancel counter
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    ldSize_d   = ldSize_q;
    ldSigned_d = ldSigned_q;
    waitResp_d = waitResp_q;
    dest_d     = dest_q;
    grWe_d     = grWe_q;
    ex_d       = ex_q;
    ertn_d     = ertn_q;
    bufFlag_d  = bufFlag_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;

    if (flush_i) begin
      valid_d   = 1'b0;
      bufFlag_d = 1'b0;
    end else if (inReady) begin
      valid_d   = bus.in_valid;
      bufFlag_d = 1'b0;
      if (bus.in_valid) begin
        pc_d       = bus.in_pc;
        addr_d     = bus.in_addr;
        ldSize_d   = bus.in_ld_size;
        ldSigned_d = bus.in_ld_signed;
        waitResp_d = bus.in_wait_resp;
        dest_d     = bus.in_dest;
        grWe_d     = bus.in_gr_we;
        ex_d       = bus.in_ex;
        ertn_d     = bus.in_ertn;
      end
    end else if (consume & ~bus.out_ready) begin
      buf_d     = bus.rdata;
      bufFlag_d = 1'b1;
    end

    if (needCancel & ~dropResp) begin
      if (cntFull) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (dropResp & ~needCancel) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      addr_q     <= '0;
      ldSize_q   <= 2'b00;
      ldSigned_q <= 1'b0;
      waitResp_q <= 1'b0;
      dest_q     <= 5'd0;
      grWe_q     <= 1'b0;
      ex_q       <= 1'b0;
      ertn_q     <= 1'b0;
      bufFlag_q  <= 1'b0;
      buf_q      <= 32'd0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      ldSize_q   <= ldSize_d;
      ldSigned_q <= ldSigned_d;
      waitResp_q <= waitResp_d;
      dest_q     <= dest_d;
      grWe_q     <= grWe_d;
      ex_q       <= ex_d;
      ertn_q     <= ertn_d;
      bufFlag_q  <= bufFlag_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Outputs toward WB and ID, all derived from held state and the live response
  always_comb begin
    bus.in_ready   = inReady;
    bus.out_valid  = valid_q & readyGo;
    bus.out_pc     = pc_q;
    bus.out_dest   = dest_q;
    bus.out_result = result;
    bus.out_gr_we  = grWe_q;
    bus.out_ex     = ex_q;
    bus.out_ertn   = ertn_q;
    bus.fwd_dest   = (valid_q & grWe_q) ? dest_q : 5'd0;
    bus.fwd_data   = result;
    bus.fwd_stall  = valid_q & (ldSize_q != 2'b00) & ~respHere;
    cancel_ovf_o   = ovf_q;
  end

endmodule

// File: tb/tb_mem_stage_vlat.sv
// Directed bench for mem_stage_vlat. Each issued instruction that should
// reach WB pushes its hand-computed result into a scoreboard; a monitor
// pops and compares whenever WB accepts an instruction.
module tb_mem_stage_vlat;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        grWe;
  } exp_t;

  logic clk;
  logic reset;
  logic flush;
  logic cancelOvf;
  int   checks;
  int   failures;
  exp_t sbQ[$];

  mem_stage_vlat_if #(.PC_W(32)) bus ();

  mem_stage_vlat #(.PC_W(32), .CANCEL_MAX(3), .CNT_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush),
    .cancel_ovf_o (cancelOvf),
    .bus          (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] addr, input logic [1:0] size,
                               input logic sgn, input logic waitResp, input logic [4:0] dest,
                               input logic grWe);
    bus.in_valid     = 1'b1;
    bus.in_pc        = pc;
    bus.in_addr      = addr;
    bus.in_ld_size   = size;
    bus.in_ld_signed = sgn;
    bus.in_wait_resp = waitResp;
    bus.in_dest      = dest;
    bus.in_gr_we     = grWe;
    bus.in_ex        = 1'b0;
    bus.in_ertn      = 1'b0;
    #1;
    checkOutput("issue_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic expectWb(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] res,
                          input logic grWe);
    exp_t e;
    e.pc     = pc;
    e.dest   = dest;
    e.result = res;
    e.grWe   = grWe;
    sbQ.push_back(e);
  endtask

  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready && !flush && !reset) begin
        if (sbQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL wb_unexpected: got pc 0x%08h expected no transfer", bus.out_pc);
        end else begin
          e = sbQ.pop_front();
          checkOutput("wb_pc", bus.out_pc, e.pc);
          checkOutput("wb_dest", 32'(bus.out_dest), 32'(e.dest));
          checkOutput("wb_result", bus.out_result, e.result);
          checkOutput("wb_gr_we", 32'(bus.out_gr_we), 32'(e.grWe));
        end
      end
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset            = 1'b1;
    flush            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_pc        = 32'd0;
    bus.in_addr      = 32'd0;
    bus.in_ld_size   = 2'b00;
    bus.in_ld_signed = 1'b0;
    bus.in_wait_resp = 1'b0;
    bus.in_dest      = 5'd0;
    bus.in_gr_we     = 1'b0;
    bus.in_ex        = 1'b0;
    bus.in_ertn      = 1'b0;
    bus.data_ok      = 1'b0;
    bus.rdata        = 32'd0;
    bus.out_ready    = 1'b1;

    fork
      monitorLoop();
    join_none

    repeat (2) step();
    reset = 1'b0;
    step();
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_fwd_dest", 32'(bus.fwd_dest), 32'd0);
    checkOutput("rst_fwd_stall", 32'(bus.fwd_stall), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_cancel_ovf", 32'(cancelOvf), 32'd0);

    // Load word answered in its first MEM cycle
    applyStimulus(32'h100, 32'h1000, 2'b11, 1'b0, 1'b1, 5'd5, 1'b1);
    expectWb(32'h100, 5'd5, 32'hDEADBEEF, 1'b1);
    step();
    bus.in_valid = 1'b0;
    bus.data_ok  = 1'b1;
    bus.rdata    = 32'hDEADBEEF;
    #1;
    checkOutput("lw_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("lw_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.data_ok = 1'b0;

    // Byte loads at offset 2, answered after three waiting cycles
    for (int s = 0; s < 2; s++) begin
      applyStimulus(32'h104 + 32'(s * 4), 32'h2002, 2'b01, (s == 0), 1'b1, 5'd6 + 5'(s), 1'b1);
      expectWb(32'h104 + 32'(s * 4), 5'd6 + 5'(s), (s == 0) ? 32'hFFFFFF80 : 32'h00000080, 1'b1);
      step();
      bus.in_valid = 1'b0;
      for (int w = 0; w < 3; w++) begin
        #1;
        checkOutput("lb_wait_stall", 32'(bus.fwd_stall), 32'd1);
        checkOutput("lb_wait_valid", 32'(bus.out_valid), 32'd0);
        step();
      end
      bus.data_ok = 1'b1;
      bus.rdata   = 32'h0080FF00;
      #1;
      checkOutput("lb_done_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("lb_done_stall", 32'(bus.fwd_stall), 32'd0);
      step();
      bus.data_ok = 1'b0;
    end

    // Signed upper-half load buffered while WB stalls
    applyStimulus(32'h10C, 32'h3002, 2'b10, 1'b1, 1'b1, 5'd8, 1'b1);
    expectWb(32'h10C, 5'd8, 32'hFFFF8001, 1'b1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_ok   = 1'b1;
    bus.rdata     = 32'h80011234;
    #1;
    checkOutput("lh_resp_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("lh_resp_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.data_ok = 1'b0;
    bus.rdata   = 32'hBAD0BAD0;
    for (int w = 0; w < 2; w++) begin
      #1;
      checkOutput("lh_buf_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("lh_buf_result", bus.out_result, 32'hFFFF8001);
      checkOutput("lh_buf_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("lh_release_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Flush of an unanswered load; its late response must be dropped
    applyStimulus(32'h110, 32'h4000, 2'b11, 1'b0, 1'b1, 5'd9, 1'b1);
    step();
    bus.in_valid = 1'b0;
    #1;
    checkOutput("fl_pre_stall", 32'(bus.fwd_stall), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    checkOutput("fl_post_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("fl_post_stall", 32'(bus.fwd_stall), 32'd0);
    applyStimulus(32'h114, 32'h4004, 2'b11, 1'b0, 1'b1, 5'd10, 1'b1);
    expectWb(32'h114, 5'd10, 32'h22222222, 1'b1);
    step();
    bus.in_valid = 1'b0;
    bus.data_ok  = 1'b1;
    bus.rdata    = 32'h11111111;
    #1;
    checkOutput("fl_drop_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("fl_drop_stall", 32'(bus.fwd_stall), 32'd1);
    step();
    bus.data_ok = 1'b0;
    #1;
    checkOutput("fl_gap_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.data_ok = 1'b1;
    bus.rdata   = 32'h22222222;
    #1;
    checkOutput("fl_second_valid", 32'(bus.out_valid), 32'd1);
    step();
    bus.data_ok = 1'b0;

    // Flush coinciding with the response: nothing is owed afterwards
    applyStimulus(32'h118, 32'h4008, 2'b11, 1'b0, 1'b1, 5'd11, 1'b1);
    step();
    bus.in_valid = 1'b0;
    bus.data_ok  = 1'b1;
    bus.rdata    = 32'h33333333;
    flush        = 1'b1;
    step();
    flush       = 1'b0;
    bus.data_ok = 1'b0;
    applyStimulus(32'h11C, 32'h400C, 2'b11, 1'b0, 1'b1, 5'd12, 1'b1);
    expectWb(32'h11C, 5'd12, 32'h44444444, 1'b1);
    step();
    bus.in_valid = 1'b0;
    bus.data_ok  = 1'b1;
    bus.rdata    = 32'h44444444;
    #1;
    checkOutput("cf_next_valid", 32'(bus.out_valid), 32'd1);
    step();
    bus.data_ok = 1'b0;

    // Store waits for its response but reports the address
    applyStimulus(32'h120, 32'h5000, 2'b00, 1'b0, 1'b1, 5'd0, 1'b0);
    expectWb(32'h120, 5'd0, 32'h5000, 1'b0);
    step();
    bus.in_valid = 1'b0;
    #1;
    checkOutput("st_wait_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("st_wait_stall", 32'(bus.fwd_stall), 32'd0);
    checkOutput("st_fwd_dest", 32'(bus.fwd_dest), 32'd0);
    step();
    bus.data_ok = 1'b1;
    bus.rdata   = 32'h99999999;
    #1;
    checkOutput("st_done_valid", 32'(bus.out_valid), 32'd1);
    step();
    bus.data_ok = 1'b0;

    // Plain ALU op passes straight through
    applyStimulus(32'h124, 32'h1234, 2'b00, 1'b0, 1'b0, 5'd13, 1'b1);
    expectWb(32'h124, 5'd13, 32'h1234, 1'b1);
    step();
    bus.in_valid = 1'b0;
    #1;
    checkOutput("alu_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("alu_fwd_dest", 32'(bus.fwd_dest), 32'd13);
    checkOutput("alu_fwd_data", bus.fwd_data, 32'h1234);
    step();

    // Four flushes of unanswered loads saturate the cancel counter
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h200 + 32'(i * 4), 32'h6000, 2'b11, 1'b0, 1'b1, 5'd14, 1'b1);
      step();
      bus.in_valid = 1'b0;
      flush        = 1'b1;
      step();
      flush = 1'b0;
      #1;
      if (i == 2) checkOutput("sat_ovf_before", 32'(cancelOvf), 32'd0);
      if (i == 3) checkOutput("sat_ovf_after", 32'(cancelOvf), 32'd1);
    end

    // Reset while a load waits clears everything
    applyStimulus(32'h300, 32'h7000, 2'b11, 1'b0, 1'b1, 5'd15, 1'b1);
    step();
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checkOutput("mr_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mr_fwd_stall", 32'(bus.fwd_stall), 32'd0);
    checkOutput("mr_cancel_ovf", 32'(cancelOvf), 32'd0);
    checkOutput("mr_in_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(32'h304, 32'h7004, 2'b11, 1'b0, 1'b1, 5'd16, 1'b1);
    expectWb(32'h304, 5'd16, 32'h55555555, 1'b1);
    step();
    bus.in_valid = 1'b0;
    bus.data_ok  = 1'b1;
    bus.rdata    = 32'h55555555;
    #1;
    checkOutput("mr_first_resp_valid", 32'(bus.out_valid), 32'd1);
    step();
    bus.data_ok = 1'b0;
    repeat (2) step();

    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
